// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART transmitter: FSM state encoding,
// bus register offsets and status-word bit positions.
package servant_uart_pkg;

    // Transmit FSM states; PARITY is only entered in the 8E1 build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Register offsets on the single-bit address bus.
    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CTRL = 1'b1;

    // Status word bit positions.
    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;

    // Pack the status flags into the 32-bit read word.
    function automatic logic [31:0] status_word(input logic busy,
                                                input logic full,
                                                input logic ovr);
        logic [31:0] w;
        w            = '0;
        w[STAT_BUSY] = busy;
        w[STAT_FULL] = full;
        w[STAT_OVR]  = ovr;
        return w;
    endfunction

endpackage

// File: rtl/servant_uart_fifo.sv
// Small synchronous first-word-fall-through FIFO for the UART TX path.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted when a pop happens on the same cycle.
module servant_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head of queue is visible without a read strobe.
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset discards any queued bytes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/servant_uart_tx.sv
// Wishbone UART transmitter for the servant SoC (MAX1000 uart_txd pin).
// Bytes written to DATA are queued and sent as 8N1 frames at a fixed divisor.
// Build option: define SERVANT_UART_PARITY_EN to insert an even-parity bit (8E1).
module servant_uart_tx
    import servant_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_adr,
    input  logic [7:0]  i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    // Bus-side state
    logic        ack_q;
    logic [31:0] rdt_q, rdt_d;
    logic        ovr_q, ovr_d;

    // Serialiser state
    uart_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef SERVANT_UART_PARITY_EN
    logic          par_q;
`endif

    logic       bus_access, wr_data, wr_ctrl, rd_access;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_rdata;
    logic       baud_wrap, load_frame, busy;

    // An access takes effect only on the cycle its ack is generated.
    assign bus_access = i_wb_cyc & ~ack_q;
    assign wr_data    = bus_access &  i_wb_we & (i_wb_adr == ADR_DATA);
    assign wr_ctrl    = bus_access &  i_wb_we & (i_wb_adr == ADR_CTRL);
    assign rd_access  = bus_access & ~i_wb_we;

    assign baud_wrap  = (cnt_q == CNT_LAST);
    // A new frame starts from IDLE, or directly from the last STOP cycle.
    assign load_frame = ~fifo_empty &
                        ((state_q == IDLE) | ((state_q == STOP) & baud_wrap));
    assign fifo_pop   = load_frame;
    assign busy       = ~fifo_empty | (state_q != IDLE);

    servant_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .push_i  (wr_data),
        .pop_i   (fifo_pop),
        .wdata_i (i_wb_dat),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next read data and sticky overflow flag.
    always_comb begin
        rdt_d = rdt_q;
        ovr_d = ovr_q;
        if (rd_access) begin
            rdt_d = (i_wb_adr == ADR_DATA) ? status_word(busy, fifo_full, ovr_q) : '0;
        end
        if (wr_ctrl && i_wb_dat[0]) ovr_d = 1'b0;
        if (wr_data && fifo_full && !fifo_pop) ovr_d = 1'b1;
    end

    // Bus registers: single-cycle ack, held read data, overflow flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ack_q <= 1'b0;
            rdt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            ack_q <= i_wb_cyc & ~ack_q;
            rdt_q <= rdt_d;
            ovr_q <= ovr_d;
        end
    end

    // Transmit FSM with baud counter; o_tx is registered here.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef SERVANT_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (load_frame) begin
            state_q <= START;
            cnt_q   <= '0;
            shift_q <= fifo_rdata;
            tx_q    <= 1'b0;
`ifdef SERVANT_UART_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                end
                START: begin
                    if (baud_wrap) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef SERVANT_UART_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef SERVANT_UART_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_tx     = tx_q;

endmodule

// File: tb/tb_servant_uart_tx.sv
// Scoreboard bench for servant_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Bus reads and serial frames are checked by independent monitors.
`timescale 1ns/1ps
module tb_servant_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef SERVANT_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_adr = 1'b0;
    logic [7:0]  wb_dat = 8'h00;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        tx;

    always #5 clk = ~clk;

    servant_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_wb_adr (wb_adr),
        .i_wb_dat (wb_dat),
        .i_wb_we  (wb_we),
        .i_wb_cyc (wb_cyc),
        .o_wb_rdt (wb_rdt),
        .o_wb_ack (wb_ack),
        .o_tx     (tx)
    );

    typedef struct { logic [7:0] data; bit b2b; } frame_t;
    typedef struct { bit rd; logic [31:0] rdt; int tag; } ack_t;

    frame_t frame_q[$];
    ack_t   ack_q[$];
    int     total = 0;
    int     bad = 0;
    int     rd_tag = 0;
    bit     mon_en = 1'b0;
    bit     mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end else begin
            $display("check %s = %0h ok", name, got);
        end
    endtask

    task automatic wb_write(input logic adr, input logic [7:0] d);
        ack_t a;
        a.rd = 1'b0; a.rdt = '0; a.tag = 0;
        ack_q.push_back(a);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = adr; wb_dat = d;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic adr, input logic [31:0] exp);
        ack_t a;
        a.rd = 1'b1; a.rdt = exp; a.tag = rd_tag;
        rd_tag++;
        ack_q.push_back(a);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = adr;
        @(posedge clk); #1;
        wb_cyc = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit b2b);
        frame_t f;
        f.data = d; f.b2b = b2b;
        frame_q.push_back(f);
        wb_write(1'b0, d);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((frame_q.size() != 0 || mon_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("frames_drained", frame_q.size() + int'(mon_busy), 0);
        repeat (3) @(negedge clk);
    endtask

    // Ack monitor: every ack pops one queued access; reads compare data.
    initial begin
        ack_t e;
        forever begin
            @(negedge clk);
            if (wb_ack === 1'b1) begin
                if (ack_q.size() == 0) begin
                    check("spurious_ack", 1, 0);
                end else begin
                    e = ack_q.pop_front();
                    if (e.rd) check($sformatf("read%0d", e.tag), wb_rdt, e.rdt);
                    else $display("write ack");
                end
            end
        end
    end

    // Serial monitor: checks each frame cycle by cycle against the queued byte.
    initial begin
        int idle;
        int errs;
        logic [7:0] got;
        logic [NBITS-1:0] bits;
        frame_t e;
        idle = 1000;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                idle = 1000;
            end else if (tx !== 1'b0) begin
                idle++;
            end else begin
                mon_busy = 1'b1;
                if (frame_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    for (int i = 0; i < 200 && tx !== 1'b1; i++) @(negedge clk);
                end else begin
                    e = frame_q.pop_front();
                    bits = '0;
                    for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
`ifdef SERVANT_UART_PARITY_EN
                    bits[9] = ^e.data;
`endif
                    bits[NBITS-1] = 1'b1;
                    errs = 0;
                    got = '0;
                    for (int k = 0; k < NBITS; k++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (tx !== bits[k]) errs++;
                            if (k >= 1 && k <= 8 && c == CPB/2) got[k-1] = tx;
                        end
                    end
                    total++;
                    if (errs != 0 || got !== e.data || (e.b2b && idle != 0)) begin
                        bad++;
                        $display("FAIL frame: got=%02h bad_cycles=%0d gap=%0d required=%02h", got, errs, idle, e.data);
                    end else begin
                        $display("frame %02h ok gap=%0d", got, idle);
                    end
                end
                idle = 0;
                mon_busy = 1'b0;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        logic [4:0] pat;
        int n;
        int lows;
        frame_t f;
        ack_t a;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ack", wb_ack, 0);
        check("rst_rdt", wb_rdt, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        wb_read(1'b0, 32'h0);

        // Single byte, busy during frame, idle after
        send(8'h55, 1'b0);
        wb_read(1'b0, 32'h1);
        wait_idle(500);
        wb_read(1'b0, 32'h0);

        // Back-to-back frames with no idle gap
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b1);
        wait_idle(500);

        // Parity-carrying byte (three ones)
        send(8'h07, 1'b0);
        wait_idle(500);

        // Overflow: byte 6 dropped, flags sticky until cleared
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        send(8'h05, 1'b1);
        wb_write(1'b0, 8'h06);
        wb_read(1'b0, 32'h7);
        wb_read(1'b1, 32'h0);
        wb_write(1'b1, 8'hFE);
        wb_read(1'b0, 32'h7);
        wb_write(1'b1, 8'h01);
        wb_read(1'b0, 32'h3);
        wait_idle(1500);
        wb_read(1'b0, 32'h0);

        // Ack protocol: cyc held across four edges gives two acks, two pushes
        f.data = 8'h81; f.b2b = 1'b0; frame_q.push_back(f);
        f.b2b = 1'b1; frame_q.push_back(f);
        a.rd = 1'b0; a.rdt = '0; a.tag = 0;
        ack_q.push_back(a);
        ack_q.push_back(a);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 1'b0; wb_dat = 8'h81;
        pat = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pat[c] = wb_ack;
            @(posedge clk); #1;
            if (c == 3) begin
                wb_cyc = 1'b0;
                wb_we = 1'b0;
            end
        end
        check("ack_pattern", {27'b0, pat}, 32'h0A);
        wait_idle(500);

        // Reset during data bit 3 aborts the frame and flushes the FIFO
        mon_en = 1'b0;
        wb_write(1'b0, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 200);
        check("abort_start_seen", (n < 200), 1);
        wb_write(1'b0, 8'h00);
        repeat (16) @(negedge clk);
        check("abort_bit3_low", tx, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_tx_high", tx, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(1'b0, 32'h0);
        lows = 0;
        repeat (120) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_residual_frame", lows, 0);
        mon_en = 1'b1;

        wait_idle(200);
        check("ack_drained", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
